// File: rtl/vrf_pkg.sv
// Shared defaults for the vector register file and its lane slices.
package vrf_pkg;

  localparam int DEF_ELEM_WIDTH  = 32;
  localparam int DEF_LANES       = 4;
  localparam int DEF_REG_COUNT   = 16;
  localparam int DEF_ADDR_NUMBER = 5;

  // Width of one lane slice inside a packed vector.
  localparam int LANE_SLICE_W    = DEF_ELEM_WIDTH;

endpackage

// File: rtl/vrf_lane.sv
// One lane of the register file: storage for every register's element in
// this lane, a masked write port and two read ports with write bypass.
module vrf_lane
  import vrf_pkg::*;
#(
  parameter int ELEM_WIDTH  = LANE_SLICE_W,
  parameter int REG_COUNT   = DEF_REG_COUNT,
  parameter int ADDR_NUMBER = DEF_ADDR_NUMBER
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [ADDR_NUMBER-1:0] wr_addr,
  input  logic [ELEM_WIDTH-1:0]  wr_data,
  input  logic [ADDR_NUMBER-1:0] rd_addr_1,
  input  logic [ADDR_NUMBER-1:0] rd_addr_2,
  output logic [ELEM_WIDTH-1:0]  rd_data_1,
  output logic [ELEM_WIDTH-1:0]  rd_data_2
);

  logic [ELEM_WIDTH-1:0] mem [REG_COUNT];

  // Element storage; wr_en arrives already qualified by enable, range and mask.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < REG_COUNT; i++)
        if (wr_addr == ADDR_NUMBER'(i)) mem[i] <= wr_data;
    end
  end

  // Read muxes; a same-cycle write to the read address forwards the new element.
  always_comb begin
    rd_data_1 = '0;
    rd_data_2 = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (rd_addr_1 == ADDR_NUMBER'(i)) rd_data_1 = mem[i];
      if (rd_addr_2 == ADDR_NUMBER'(i)) rd_data_2 = mem[i];
    end
    if (wr_en && (wr_addr == rd_addr_1)) rd_data_1 = wr_data;
    if (wr_en && (wr_addr == rd_addr_2)) rd_data_2 = wr_data;
  end

endmodule

// File: rtl/vector_register_file.sv
// Vector register file with per-lane masked writes, two registered read
// ports, a busy scoreboard and out-of-range address reporting.
module vector_register_file
  import vrf_pkg::*;
#(
  parameter int ELEM_WIDTH  = DEF_ELEM_WIDTH,
  parameter int LANES       = DEF_LANES,
  parameter int REG_COUNT   = DEF_REG_COUNT,
  parameter int ADDR_NUMBER = DEF_ADDR_NUMBER
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        rd_en,
  input  logic [ADDR_NUMBER-1:0]      src_addr_1,
  input  logic [ADDR_NUMBER-1:0]      src_addr_2,
  input  logic                        wr_en,
  input  logic [ADDR_NUMBER-1:0]      dest_addr,
  input  logic [LANES*ELEM_WIDTH-1:0] write_data,
  input  logic [LANES-1:0]            write_mask,
  input  logic                        reserve_en,
  input  logic [ADDR_NUMBER-1:0]      reserve_addr,
  output logic [LANES*ELEM_WIDTH-1:0] data_out_1,
  output logic [LANES*ELEM_WIDTH-1:0] data_out_2,
  output logic                        busy_1,
  output logic                        busy_2,
  output logic                        rd_valid,
  output logic                        addr_err
);

  localparam int VEC_W = LANES * ELEM_WIDTH;

  logic                 rd_ok_1, rd_ok_2, wr_ok, res_ok;
  logic                 rd_acc, wr_acc, res_acc, err;
  logic                 busy_rd_1, busy_rd_2;
  logic [REG_COUNT-1:0] busy, busy_next;
  logic [VEC_W-1:0]     lane_rd_1, lane_rd_2;

  // Request qualification, post-update scoreboard and error detection.
  always_comb begin
    rd_ok_1   = int'(src_addr_1)   < REG_COUNT;
    rd_ok_2   = int'(src_addr_2)   < REG_COUNT;
    wr_ok     = int'(dest_addr)    < REG_COUNT;
    res_ok    = int'(reserve_addr) < REG_COUNT;
    rd_acc    = enable & rd_en;
    wr_acc    = enable & wr_en & wr_ok;
    res_acc   = enable & reserve_en & res_ok;
    err       = enable & ((rd_en & (~rd_ok_1 | ~rd_ok_2)) |
                          (wr_en & ~wr_ok) | (reserve_en & ~res_ok));
    busy_next = busy;
    busy_rd_1 = 1'b0;
    busy_rd_2 = 1'b0;
    // Clear on write first, then set on reserve so a reservation wins.
    for (int i = 0; i < REG_COUNT; i++) begin
      if (wr_acc  && dest_addr    == ADDR_NUMBER'(i)) busy_next[i] = 1'b0;
      if (res_acc && reserve_addr == ADDR_NUMBER'(i)) busy_next[i] = 1'b1;
    end
    for (int i = 0; i < REG_COUNT; i++) begin
      if (src_addr_1 == ADDR_NUMBER'(i)) busy_rd_1 = busy_next[i];
      if (src_addr_2 == ADDR_NUMBER'(i)) busy_rd_2 = busy_next[i];
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    vrf_lane #(
      .ELEM_WIDTH (ELEM_WIDTH),
      .REG_COUNT  (REG_COUNT),
      .ADDR_NUMBER(ADDR_NUMBER)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_acc & write_mask[k]),
      .wr_addr  (dest_addr),
      .wr_data  (write_data[k*ELEM_WIDTH +: ELEM_WIDTH]),
      .rd_addr_1(src_addr_1),
      .rd_addr_2(src_addr_2),
      .rd_data_1(lane_rd_1[k*ELEM_WIDTH +: ELEM_WIDTH]),
      .rd_data_2(lane_rd_2[k*ELEM_WIDTH +: ELEM_WIDTH])
    );
  end

  // Scoreboard state and registered read/strobe outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy       <= '0;
      data_out_1 <= '0;
      data_out_2 <= '0;
      busy_1     <= 1'b0;
      busy_2     <= 1'b0;
      rd_valid   <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      busy     <= busy_next;
      rd_valid <= rd_acc;
      addr_err <= err;
      if (rd_acc) begin
        data_out_1 <= rd_ok_1 ? lane_rd_1 : '0;
        data_out_2 <= rd_ok_2 ? lane_rd_2 : '0;
        busy_1     <= rd_ok_1 & busy_rd_1;
        busy_2     <= rd_ok_2 & busy_rd_2;
      end
    end
  end

endmodule

// File: tb/tb_vector_register_file.sv
// Self-checking bench for vector_register_file with a behavioural model.
module tb_vector_register_file;

  localparam int EW = 32;
  localparam int NL = 4;
  localparam int RC = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable, rd_en, wr_en, reserve_en;
  logic [AW-1:0] src_addr_1, src_addr_2, dest_addr, reserve_addr;
  logic [127:0]  write_data;
  logic [NL-1:0] write_mask;
  logic [127:0]  data_out_1, data_out_2;
  logic          busy_1, busy_2, rd_valid, addr_err;

  int total = 0;
  int bad   = 0;

  // Behavioural model: register contents, busy flags and expected outputs.
  logic [EW-1:0] m_mem [RC][NL];
  bit            m_busy [RC];
  logic [127:0]  exp_d1, exp_d2;
  logic          exp_b1, exp_b2, exp_valid, exp_err;

  vector_register_file #(.ELEM_WIDTH(EW), .LANES(NL), .REG_COUNT(RC), .ADDR_NUMBER(AW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rd_en(rd_en),
    .src_addr_1(src_addr_1), .src_addr_2(src_addr_2), .wr_en(wr_en),
    .dest_addr(dest_addr), .write_data(write_data), .write_mask(write_mask),
    .reserve_en(reserve_en), .reserve_addr(reserve_addr),
    .data_out_1(data_out_1), .data_out_2(data_out_2),
    .busy_1(busy_1), .busy_2(busy_2), .rd_valid(rd_valid), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] vec4(input int e3, input int e2, input int e1, input int e0);
    return {e3[31:0], e2[31:0], e1[31:0], e0[31:0]};
  endfunction

  function automatic logic [127:0] model_vec(input int a);
    logic [127:0] v = '0;
    if (a < RC) for (int k = 0; k < NL; k++) v[k*EW +: EW] = m_mem[a][k];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < RC; i++) begin
      m_busy[i] = 0;
      for (int k = 0; k < NL; k++) m_mem[i][k] = '0;
    end
    exp_d1 = '0; exp_d2 = '0; exp_b1 = 0; exp_b2 = 0; exp_valid = 0; exp_err = 0;
  endtask

  // Apply the current request set to the model: state changes first, then
  // reads observe the resulting state.
  task automatic model_step();
    int s1, s2, d, r;
    s1 = int'(src_addr_1); s2 = int'(src_addr_2);
    d  = int'(dest_addr);  r  = int'(reserve_addr);
    if (!enable) begin
      exp_valid = 0; exp_err = 0;
      return;
    end
    exp_err = (rd_en && (s1 >= RC || s2 >= RC)) || (wr_en && d >= RC) || (reserve_en && r >= RC);
    if (wr_en && d < RC) begin
      for (int k = 0; k < NL; k++) if (write_mask[k]) m_mem[d][k] = write_data[k*EW +: EW];
      m_busy[d] = 0;
    end
    if (reserve_en && r < RC) m_busy[r] = 1;
    exp_valid = rd_en;
    if (rd_en) begin
      exp_d1 = model_vec(s1);
      exp_d2 = model_vec(s2);
      exp_b1 = (s1 < RC) ? m_busy[s1] : 1'b0;
      exp_b2 = (s2 < RC) ? m_busy[s2] : 1'b0;
    end
  endtask

  task automatic idle();
    enable = 1; rd_en = 0; wr_en = 0; reserve_en = 0;
    src_addr_1 = '0; src_addr_2 = '0; dest_addr = '0; reserve_addr = '0;
    write_data = '0; write_mask = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input logic [127:0] v, input logic [3:0] m);
    idle(); wr_en = 1; dest_addr = AW'(a); write_data = v; write_mask = m;
    tick();
  endtask

  task automatic do_read(input int a1, input int a2);
    idle(); rd_en = 1; src_addr_1 = AW'(a1); src_addr_2 = AW'(a2);
    tick();
  endtask

  task automatic test_reset();
    total++;
    if ({data_out_1, data_out_2, busy_1, busy_2, rd_valid, addr_err} !== '0) begin
      bad++; $display("FAIL reset_outputs got d1=%h valid=%b err=%b want all zero", data_out_1, rd_valid, addr_err);
    end
    do_read(3, 9);
    total++;
    if (data_out_1 !== '0 || data_out_2 !== '0 || rd_valid !== 1'b1) begin
      bad++; $display("FAIL reset_storage got d1=%h d2=%h valid=%b want 0 0 1", data_out_1, data_out_2, rd_valid);
    end
  endtask

  task automatic test_write_read();
    do_write(3, vec4(4, 3, 2, 1), 4'b1111);
    total++;
    if (rd_valid !== 1'b0) begin bad++; $display("FAIL wr_no_valid got %b want 0", rd_valid); end
    do_read(3, 0);
    total++;
    if (data_out_1 !== vec4(4, 3, 2, 1) || rd_valid !== 1'b1) begin
      bad++; $display("FAIL write_read got d1=%h valid=%b want %h 1", data_out_1, rd_valid, vec4(4, 3, 2, 1));
    end
    idle(); tick();
    total++;
    if (rd_valid !== 1'b0 || data_out_1 !== vec4(4, 3, 2, 1)) begin
      bad++; $display("FAIL read_hold got d1=%h valid=%b want held data, valid 0", data_out_1, rd_valid);
    end
  endtask

  task automatic test_masked_bypass();
    do_write(5, vec4('hA, 'hB, 'hC, 'hD), 4'b1111);
    idle(); wr_en = 1; dest_addr = 5; write_data = vec4(1, 2, 3, 4); write_mask = 4'b0101;
    rd_en = 1; src_addr_1 = 5; src_addr_2 = 5;
    tick();
    total++;
    if (data_out_1 !== vec4('hA, 2, 'hC, 4) || data_out_2 !== data_out_1) begin
      bad++; $display("FAIL masked_bypass got d1=%h d2=%h want %h", data_out_1, data_out_2, vec4('hA, 2, 'hC, 4));
    end
    do_write(5, vec4(9, 9, 9, 9), 4'b0000);
    do_read(5, 3);
    total++;
    if (data_out_1 !== vec4('hA, 2, 'hC, 4) || data_out_2 !== vec4(4, 3, 2, 1)) begin
      bad++; $display("FAIL zero_mask got d1=%h d2=%h want %h %h", data_out_1, data_out_2, vec4('hA, 2, 'hC, 4), vec4(4, 3, 2, 1));
    end
  endtask

  task automatic test_scoreboard();
    idle(); reserve_en = 1; reserve_addr = 7; tick();
    do_read(7, 6);
    total++;
    if (busy_1 !== 1'b1 || busy_2 !== 1'b0) begin
      bad++; $display("FAIL reserve_busy got b1=%b b2=%b want 1 0", busy_1, busy_2);
    end
    do_write(7, vec4(7, 7, 7, 7), 4'b0000);
    do_read(7, 7);
    total++;
    if (busy_1 !== 1'b0 || busy_2 !== 1'b0) begin
      bad++; $display("FAIL write_clears got b1=%b b2=%b want 0 0", busy_1, busy_2);
    end
    idle(); reserve_en = 1; reserve_addr = 7; wr_en = 1; dest_addr = 7;
    write_data = vec4(8, 8, 8, 8); write_mask = 4'b1111; rd_en = 1; src_addr_1 = 7; src_addr_2 = 7;
    tick();
    total++;
    if (busy_1 !== 1'b1 || data_out_1 !== vec4(8, 8, 8, 8)) begin
      bad++; $display("FAIL reserve_wins got b1=%b d1=%h want 1 %h", busy_1, data_out_1, vec4(8, 8, 8, 8));
    end
    do_read(7, 0);
    total++;
    if (busy_1 !== 1'b1) begin bad++; $display("FAIL reserve_persist got %b want 1", busy_1); end
  endtask

  task automatic test_addr_err();
    do_write(4, vec4(44, 43, 42, 41), 4'b1111);
    do_write(20, vec4(1, 1, 1, 1), 4'b1111);
    total++;
    if (addr_err !== 1'b1) begin bad++; $display("FAIL err_write got %b want 1", addr_err); end
    do_read(20, 4);
    total++;
    if (addr_err !== 1'b1 || data_out_1 !== '0 || busy_1 !== 1'b0 || data_out_2 !== vec4(44, 43, 42, 41)) begin
      bad++; $display("FAIL err_read got err=%b d1=%h d2=%h want 1 0 %h", addr_err, data_out_1, data_out_2, vec4(44, 43, 42, 41));
    end
    idle(); tick();
    total++;
    if (addr_err !== 1'b0) begin bad++; $display("FAIL err_pulse got %b want 0", addr_err); end
  endtask

  task automatic test_enable();
    do_read(3, 3);
    idle(); enable = 0; rd_en = 1; wr_en = 1; reserve_en = 1; reserve_addr = 3;
    src_addr_1 = 5; dest_addr = 3; write_data = vec4(0, 0, 0, 0); write_mask = 4'b1111;
    tick();
    total++;
    if (rd_valid !== 1'b0 || data_out_1 !== vec4(4, 3, 2, 1)) begin
      bad++; $display("FAIL enable_off got valid=%b d1=%h want 0 %h", rd_valid, data_out_1, vec4(4, 3, 2, 1));
    end
    do_read(3, 3);
    total++;
    if (data_out_1 !== vec4(4, 3, 2, 1) || busy_1 !== 1'b0) begin
      bad++; $display("FAIL enable_blocked got d1=%h b1=%b want %h 0", data_out_1, busy_1, vec4(4, 3, 2, 1));
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      enable     = ($urandom_range(0, 9) != 0);
      rd_en      = $urandom_range(0, 1);
      wr_en      = $urandom_range(0, 1);
      reserve_en = ($urandom_range(0, 3) == 0);
      src_addr_1 = AW'($urandom_range(0, 17));
      src_addr_2 = ($urandom_range(0, 3) == 0) ? src_addr_1 : AW'($urandom_range(0, 17));
      dest_addr  = AW'($urandom_range(0, 17));
      reserve_addr = AW'($urandom_range(0, 17));
      write_data = {$urandom, $urandom, $urandom, $urandom};
      write_mask = NL'($urandom);
      tick();
      total++;
      if (data_out_1 !== exp_d1 || data_out_2 !== exp_d2 || busy_1 !== exp_b1 || busy_2 !== exp_b2 ||
          rd_valid !== exp_valid || addr_err !== exp_err) begin
        bad++;
        $display("FAIL random[%0d] got d1=%h d2=%h b=%b%b v=%b e=%b want d1=%h d2=%h b=%b%b v=%b e=%b",
                 n, data_out_1, data_out_2, busy_1, busy_2, rd_valid, addr_err,
                 exp_d1, exp_d2, exp_b1, exp_b2, exp_valid, exp_err);
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_write(2, vec4(5, 6, 7, 8), 4'b1111);
    idle(); reserve_en = 1; reserve_addr = 2; tick();
    do_read(2, 2);
    #2 reset = 0;
    #1;
    total++;
    if ({data_out_1, data_out_2, busy_1, busy_2, rd_valid, addr_err} !== '0) begin
      bad++; $display("FAIL reset_async got d1=%h b1=%b valid=%b want all zero", data_out_1, busy_1, rd_valid);
    end
    model_clear();
    idle(); rd_en = 1; wr_en = 1; dest_addr = 2; write_mask = 4'b1111; write_data = vec4(1, 1, 1, 1);
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1;
    idle(); tick();
    do_read(2, 2);
    total++;
    if (data_out_1 !== '0 || busy_1 !== 1'b0) begin
      bad++; $display("FAIL reset_cleared got d1=%h b1=%b want 0 0", data_out_1, busy_1);
    end
  endtask

  initial begin
    reset = 0;
    idle();
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1;
    @(posedge clk); #1;
    test_reset();
    test_write_read();
    test_masked_bypass();
    test_scoreboard();
    test_addr_err();
    test_enable();
    test_random();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_register_file.md
VECTOR_REGISTER_FILE -- requirements
Module: vector_register_file

Interface
REQ-001 SHALL have parameter ELEM_WIDTH, default 32, meaning bits per lane element.
REQ-002 SHALL have parameter LANES, default 4, meaning elements per vector register.
REQ-003 SHALL have parameter REG_COUNT, default 16, meaning implemented registers.
REQ-004 SHALL have parameter ADDR_NUMBER, default 5, meaning address width; 2**ADDR_NUMBER >= REG_COUNT.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1, meaning global clock-enable; low freezes all state and outputs.
REQ-008 SHALL have port rd_en, input, 1, meaning read request.
REQ-009 SHALL have ports src_addr_1 and src_addr_2, input, ADDR_NUMBER each, meaning read addresses.
REQ-010 SHALL have port wr_en, input, 1, meaning write request.
REQ-011 SHALL have port dest_addr, input, ADDR_NUMBER, meaning write address.
REQ-012 SHALL have port write_data, input, LANES*ELEM_WIDTH, meaning write vector; lane k at bits [k*ELEM_WIDTH +: ELEM_WIDTH].
REQ-013 SHALL have port write_mask, input, LANES, meaning per-lane write enable.
REQ-014 SHALL have ports reserve_en (1) and reserve_addr (ADDR_NUMBER), input, meaning scoreboard reservation.
REQ-015 SHALL have ports data_out_1 and data_out_2, output, LANES*ELEM_WIDTH each, meaning registered read data.
REQ-016 SHALL have ports busy_1 and busy_2, output, 1 each, meaning registered scoreboard state of the read source.
REQ-017 SHALL have port rd_valid, output, 1, meaning read data valid strobe.
REQ-018 SHALL have port addr_err, output, 1, meaning out-of-range address strobe.

Function
REQ-019 Read latency SHALL be one cycle: rd_en=1 and enable=1 at edge N yields data, busy bits and rd_valid=1 after edge N; rd_valid SHALL be 0 in all other cycles.
REQ-020 data_out_* and busy_* SHALL hold their values when no read is accepted.
REQ-021 Write SHALL update only lanes with write_mask[k]=1 at dest_addr; mask all-zero SHALL leave storage unchanged but still clear busy.
REQ-022 Same-cycle read and write to the same address SHALL return the merged new value (masked lanes new, others old); the busy bit SHALL read as post-update value.
REQ-023 Accepted write SHALL clear busy[dest_addr]; accepted reserve SHALL set busy[reserve_addr].
REQ-024 Simultaneous reserve and write to the same address SHALL leave busy set (reserve wins); data is still written.
REQ-025 Address >= REG_COUNT: write/reserve SHALL be ignored, read SHALL return all-zero data and busy 0, addr_err SHALL pulse 1 for one cycle.
REQ-026 Both read ports SHALL be independent; identical src addresses SHALL return identical data.
REQ-027 enable=0 SHALL block read, write and reserve; rd_valid and addr_err SHALL be 0 in the following cycle.

Reset
REQ-028 reset=0 SHALL immediately clear all storage, busy bits, data_out_*, busy_*, rd_valid and addr_err to 0, regardless of clk or enable.
REQ-029 Requests present during reset or on the edge coinciding with deassertion SHALL be discarded; first operation accepted on the next rising edge.

Structure
REQ-030 Package vrf_pkg SHALL hold default parameter values and the lane-slice width constant.
REQ-031 One sub-module vrf_lane SHALL implement per-lane storage, masked write and bypass, instantiated LANES times; scoreboard and error logic stay in the top.

Verification
REQ-032 Reset, write reg 3 = {4,3,2,1} mask 1111, read src1=3 -> one cycle later data_out_1 = {4,3,2,1}, rd_valid=1.
REQ-033 Reg 5 = {A,B,C,D}, write {1,2,3,4} mask 0101 with same-cycle read of 5 -> data_out = {A,2,C,4}.
REQ-034 Reserve 7, read 7 -> busy_1=1; write 7 -> next read busy_1=0; reserve+write 7 together -> busy stays 1.
REQ-035 Write/read address 20 (REG_COUNT=16) -> addr_err=1 one cycle, data_out=0, storage unchanged.
REQ-036 enable=0 with rd_en, wr_en -> no change, rd_valid=0; reset=0 mid-stream -> all outputs 0 immediately.
